// File: rtl/pipelined_cla_addsub_if.sv
// Handshake and operand/result bundle for pipelined_cla_addsub.
// master = producer/consumer side, slave = the adder itself.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Two-stage block carry-lookahead adder/subtractor with valid/ready handshakes.
// Optional saturation on signed overflow: define PIPELINED_CLA_SATURATE_EN.
module pipelined_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_addsub_if.slave bus
);

  localparam int NB  = WIDTH / BLOCK;
  localparam int MSB = WIDTH - 1;

  // Handshake
  logic w_s2_free;
  logic w_s1_advance;
  logic w_in_accept;

  // Stage-1 combinational
  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;
  logic [NB-1:0]    w_blk_g;
  logic [NB-1:0]    w_blk_p;

  // Stage-1 registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_c0;
  logic [NB-1:0]    r_s1_g;
  logic [NB-1:0]    r_s1_p;

  // Stage-2 combinational
  logic [WIDTH-1:0] w_sum_raw;
  logic [WIDTH-1:0] w_sum_res;
  logic             w_cout;
  logic             w_ovf;

  // Stage-2 / output registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // in_ready depends only on state and out_ready, never on in_valid.
  assign w_s2_free    = !r_s2_valid || bus.out_ready;
  assign w_s1_advance = r_s1_valid && w_s2_free;
  assign bus.in_ready = !r_s1_valid || w_s1_advance;
  assign w_in_accept  = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: effective operands and per-block group generate/propagate
  // ---------------------------------------------------------------------------
  always_comb begin : stage1_lookahead
    logic g_acc;
    logic p_acc;
    logic g_bit;
    logic p_bit;
    // NOTE: every output gets a default first so no path can infer a latch.
    w_a_eff = bus.a;
    w_b_eff = bus.sub ? ~bus.b : bus.b;
    w_c0    = bus.sub | bus.cin;
    w_blk_g = '0;
    w_blk_p = '0;
    for (int k = 0; k < NB; k++) begin
      g_acc = 1'b0;
      p_acc = 1'b1;
      // NOTE: blocking assignments here build the in-order fold; the
      // sequential blocks below use non-blocking assignments only.
      for (int j = 0; j < BLOCK; j++) begin
        g_bit = w_a_eff[k*BLOCK+j] & w_b_eff[k*BLOCK+j];
        p_bit = w_a_eff[k*BLOCK+j] ^ w_b_eff[k*BLOCK+j];
        g_acc = g_bit | (p_bit & g_acc);
        p_acc = p_acc & p_bit;
      end
      w_blk_g[k] = g_acc;
      w_blk_p[k] = p_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_valid;
    end
  end

  // NOTE: datapath registers are left unreset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_in_accept) begin
      r_s1_a  <= w_a_eff;
      r_s1_b  <= w_b_eff;
      r_s1_c0 <= w_c0;
      r_s1_g  <= w_blk_g;
      r_s1_p  <= w_blk_p;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: block carry chain, in-block sum bits, cout and ovf
  // ---------------------------------------------------------------------------
  always_comb begin : stage2_carry
    logic c_blk;
    logic c_bit;
    logic g_bit;
    logic p_bit;
    w_sum_raw = '0;
    c_blk     = r_s1_c0;
    for (int k = 0; k < NB; k++) begin
      // Bits inside a block ripple from the lookahead carry into that block.
      c_bit = c_blk;
      for (int j = 0; j < BLOCK; j++) begin
        g_bit                = r_s1_a[k*BLOCK+j] & r_s1_b[k*BLOCK+j];
        p_bit                = r_s1_a[k*BLOCK+j] ^ r_s1_b[k*BLOCK+j];
        w_sum_raw[k*BLOCK+j] = p_bit ^ c_bit;
        c_bit                = g_bit | (p_bit & c_bit);
      end
      c_blk = r_s1_g[k] | (r_s1_p[k] & c_blk);
    end
    w_cout = c_blk;
  end

  assign w_ovf = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_sum_raw[MSB] != r_s1_a[MSB]);

`ifdef PIPELINED_CLA_SATURATE_EN
  // Overflow direction follows the shared operand sign.
  always_comb begin
    w_sum_res = w_sum_raw;
    if (w_ovf) begin
      w_sum_res = r_s1_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end
`else
  assign w_sum_res = w_sum_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s1_advance) begin
        r_sum  <= w_sum_res;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (WIDTH=32, BLOCK=4); honours
// PIPELINED_CLA_SATURATE_EN for its expected values.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

`ifdef PIPELINED_CLA_SATURATE_EN
  localparam logic [31:0] POS_OVF_SUM = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_OVF_SUM = 32'h8000_0000;
`else
  localparam logic [31:0] POS_OVF_SUM = 32'h8000_0000;
  localparam logic [31:0] NEG_OVF_SUM = 32'h7FFF_FFFF;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   run_len;
  int   max_run;
  bit   rand_bp;
  res_t sb_q[$];
  res_t mon_exp;

  pipelined_cla_addsub_if #(.WIDTH(32)) bus ();

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden model straight from the arithmetic definition.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] be;
    logic [32:0] t;
    res_t        r;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'b0, (sub ? 1'b1 : cin)};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
`ifdef PIPELINED_CLA_SATURATE_EN
    if (r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      run_len = 0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      if (bus.out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got sum=%h cout=%b ovf=%b, required no output",
                   bus.sum, bus.cout, bus.ovf);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({bus.sum, bus.cout, bus.ovf} !== mon_exp) begin
            n_err++;
            $display("FAIL sb_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     bus.sum, bus.cout, bus.ovf, mon_exp.sum, mon_exp.cout, mon_exp.ovf);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    bit done = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready never high, required an accept");
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h1234_5678;
    bus.b         = 32'h0000_0001;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got out_valid=%b sum=%h cout=%b ovf=%b in_ready=%b, required 0 0 0 0 1",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_ignore_in: got out_valid=%b, required 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_directed();
    vec_t tbl[7];
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, POS_OVF_SUM,   1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, NEG_OVF_SUM,   1'b1, 1'b1};
    tbl[4] = '{32'h0000_000F, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0011, 1'b0, 1'b0};
    tbl[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    drain();
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL latency_early[%0d]: got out_valid=%b one cycle after accept, required 0",
                 i, bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, tbl[i].s, tbl[i].co, tbl[i].ov}) begin
        n_err++;
        $display("FAIL directed[%0d]: got valid=%b sum=%h cout=%b ovf=%b, required 1 sum=%h cout=%b ovf=%b",
                 i, bus.out_valid, bus.sum, bus.cout, bus.ovf, tbl[i].s, tbl[i].co, tbl[i].ov);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int start;
    bus.out_ready = 1'b1;
    drain();
    max_run = 0;
    start   = cyc;
    for (int i = 0; i < 10; i++)
      send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_vec++;
    if (cyc - start != 10) begin
      n_err++;
      $display("FAIL b2b_throughput: got %0d cycles for 10 accepts, required 10", cyc - start);
    end
    drain();
    n_vec++;
    if (max_run != 10) begin
      n_err++;
      $display("FAIL b2b_out_run: got %0d consecutive out_valid, required 10", max_run);
    end
  endtask

  task automatic test_stall();
    logic [31:0] sa[3];
    logic [31:0] sb[3];
    res_t        e0;
    int          acc = 0;
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    sa = '{32'h1111_1111, 32'h7FFF_FFFF, 32'h0000_00FF};
    sb = '{32'h2222_2222, 32'h0000_0001, 32'hFFFF_FF01};
    e0 = model(sa[0], sb[0], 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.a        = sa[(acc > 2) ? 2 : acc];
      bus.b        = sb[(acc > 2) ? 2 : acc];
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_ready) acc++;
      if (c >= 2) begin
        n_vec++;
        if ({bus.out_valid, bus.in_ready, bus.sum} !== {1'b1, 1'b0, e0.sum}) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: got out_valid=%b in_ready=%b sum=%h, required 1 0 %h",
                   c, bus.out_valid, bus.in_ready, bus.sum, e0.sum);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (acc != 2) begin
      n_err++;
      $display("FAIL stall_accepts: got %0d accepts, required 2", acc);
    end
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_in_flight();
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0BAD_F00D, 32'h0000_0010, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.sum, bus.in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL flight_reset: got out_valid=%b sum=%h in_ready=%b, required 0 0 1",
               bus.out_valid, bus.sum, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flight_discard[%0d]: got out_valid=%b, required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random_backpressure();
    logic [31:0] edge_v[5];
    logic [31:0] ra;
    logic [31:0] rb;
    edge_v = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    bus.out_ready = 1'b1;
    drain();
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom();
      rb = ($urandom_range(0, 2) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom();
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    run_len = 0;
    max_run = 0;
    rand_bp = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
    test_random_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; a multiple of BLOCK, with WIDTH >= BLOCK.
REQ-002 SHALL have parameter BLOCK, default 4: bits per lookahead block; one of 2, 4 or 8.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in; used in add mode only.
REQ-010 SHALL have port sub, input, 1: 0 = A+B+cin; 1 = A-B.
REQ-011 SHALL have port out_valid, output, 1: the result is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: raw carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1: signed (two's-complement) overflow of the operation.

Function
REQ-016 SHALL compute add as A + B + cin, and sub as A + ~B + 1; cin is ignored when sub=1.
REQ-017 SHALL take a transfer on each side only when valid and ready are both high in the same cycle.
REQ-018 Stage 1 SHALL register the effective operands, carry-in and the per-block generate/propagate for the WIDTH/BLOCK blocks:
- G = g[n-1] | p[n-1]&g[n-2] | ... | p[n-1..1]&g[0]
- P = AND of all bit-level p, where p = a XOR b.
REQ-019 Stage 2 SHALL derive block carries C[k+1] = G[k] | P[k]&C[k] from the stage-1 registers, then form sum, cout and ovf and register them to the outputs.
REQ-020 Latency SHALL be exactly 2 cycles (input transfer on cycle N gives out_valid on cycle N+2) with no stall; throughput SHALL be 1 result per cycle.
REQ-021 ovf SHALL be (a_eff[MSB] == b_eff[MSB]) && (sum_raw[MSB] != a_eff[MSB]), where b_eff is the inverted B in sub mode.
REQ-022 Backpressure rules:
- stage 2 holds its result while out_valid && !out_ready;
- stage 1 advances only when stage 2 is empty or is draining this cycle;
- in_ready = !s1_valid || s1_advance.
REQ-023 While stalled, sum, cout and ovf SHALL stay stable and no operand SHALL be dropped or duplicated.
REQ-024 SHALL handle a simultaneous input accept and output drain in one cycle without a bubble.
REQ-025 SHALL keep in_ready free of any combinational path from in_valid.

Reset
REQ-026 On rst=1 at a clock edge, both stage valid bits SHALL clear; the in-flight operations are discarded, including on a mid-operation reset.
REQ-027 After reset, out_valid=0, sum=0, cout=0 and ovf=0, and in_ready=1 from the first cycle after rst deasserts.
REQ-028 SHALL ignore in_valid in any cycle in which rst=1.

Configuration
REQ-029 When macro PIPELINED_CLA_SATURATE_EN is defined, the block SHALL saturate on ovf=1:
- positive overflow gives sum = 0 followed by WIDTH-1 ones;
- negative overflow gives sum = 1 followed by WIDTH-1 zeros;
- cout and ovf are reported unchanged.
REQ-030 When PIPELINED_CLA_SATURATE_EN is undefined, sum SHALL wrap modulo 2^WIDTH; no saturation logic SHALL be present.

Verification (WIDTH=32, BLOCK=4)
REQ-031 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 2 cycles sum=0x00000000, cout=1, ovf=0 (full carry ripple across all 8 blocks).
REQ-032 a=0x7FFFFFFF, b=0x00000001, sub=0 -> ovf=1; without the macro sum=0x80000000; with it sum=0x7FFFFFFF.
REQ-033 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1, sub=1 -> ovf=1, and with the macro sum=0x80000000.
REQ-034 10 back-to-back operations with out_ready=1 -> 10 consecutive out_valid cycles, with results in order.
REQ-035 out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 accepts; sum is held; on release, all results arrive in order with none lost.
REQ-036 rst asserted with 2 operations in flight -> out_valid=0 on the next cycle, and the discarded results never appear.
